inst_fetch: RTL and testbench

//   Instruction-fetch front end; drives the IF side of the IF/ID pipeline register.

---
 rtl/inst_fetch_if.sv | 33 +++
 rtl/inst_fetch.sv | 140 ++++++++++++++
 tb/tb_inst_fetch.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Instruction-memory port of the fetch unit: an in-order request channel
// and a response channel with no backpressure.
`timescale 1ns/1ps

interface inst_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   // A request transfers on a posedge where imem_req_valid && imem_req_ready.
   // While valid && !ready, the address is held stable. Responses return one
   // per imem_resp_valid cycle, in request order, and cannot be refused.
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_resp_valid;
   logic [INST_W-1:0] imem_resp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: owns the PC, issues credit-limited word reads,
// buffers {pc, inst} pairs and presents one per cycle to the IF/ID register.
`timescale 1ns/1ps

module inst_fetch #(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst,
   inst_fetch_if.master      imem,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              if_valid,
   output logic [ADDR_W-1:0] if_pc,
   output logic [INST_W-1:0] if_inst
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  inflight_q, inflight_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
   logic [ADDR_W-1:0] fifo_pc_d   [DEPTH];
   logic [INST_W-1:0] fifo_inst_q [DEPTH];
   logic [INST_W-1:0] fifo_inst_d [DEPTH];

   logic [CNT_W:0]    used;
   logic              credit_ok;
   logic              req_valid;
   logic              req_fire;
   logic              resp_in;
   logic              push;
   logic              pop;
   logic [CNT_W-1:0]  live;
   logic [CNT_W-1:0]  inflight_after_resp;
   logic [ADDR_W-1:0] resp_pc;

   // A slot is reserved at issue time, so the buffer can never overflow.
   assign used      = {1'b0, inflight_q} + {1'b0, count_q};
   assign credit_ok = used < (CNT_W+1)'(DEPTH);
   assign req_valid = !rst && !redirect && credit_ok;
   assign req_fire  = req_valid && imem.imem_req_ready;

   assign imem.imem_req_valid = req_valid;
   assign imem.imem_req_addr  = pc_q;

   assign resp_in = !rst && imem.imem_resp_valid;
   assign push    = resp_in && !redirect && (drop_q == '0);

   // Surviving in-flight requests are consecutive and end just below pc_q,
   // so the oldest one's PC is derived rather than stored per request.
   assign live    = inflight_q - drop_q;
   assign resp_pc = pc_q - (ADDR_W'(live) << 2);

   assign inflight_after_resp = inflight_q - CNT_W'(resp_in);

   assign if_valid = !rst && (count_q != '0);
   assign pop      = if_valid && !stall && !redirect;
   assign if_pc    = if_valid ? fifo_pc_q[rd_ptr_q]   : '0;
   assign if_inst  = if_valid ? fifo_inst_q[rd_ptr_q] : '0;

   always_comb begin
      pc_d        = pc_q;
      inflight_d  = inflight_q;
      drop_d      = drop_q;
      count_d     = count_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fifo_pc_d   = fifo_pc_q;
      fifo_inst_d = fifo_inst_q;

      if (redirect) begin
         // Every older request still outstanding is now wrong-path.
         pc_d       = redirect_pc;
         inflight_d = inflight_after_resp;
         drop_d     = inflight_after_resp;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end else begin
         if (req_fire) begin
            pc_d = pc_q + ADDR_W'(4);
         end
         inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(resp_in);
         if (resp_in && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
         end
         if (push) begin
            fifo_pc_d[wr_ptr_q]   = resp_pc;
            fifo_inst_d[wr_ptr_q] = imem.imem_resp_data;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      fifo_pc_q   <= fifo_pc_d;
      fifo_inst_q <= fifo_inst_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && (count_q == CNT_W'(DEPTH))));
         assert (!(resp_in && (inflight_q == '0)));
         assert (drop_q <= inflight_q);
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a latency-1 memory model with hold and
// request budget, plus request and output scoreboards.
`timescale 1ns/1ps

module tb_inst_fetch;

   localparam int ADDR_W = 32;
   localparam int INST_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              stall;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              if_valid;
   logic [ADDR_W-1:0] if_pc;
   logic [INST_W-1:0] if_inst;

   inst_fetch_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) imem_if ();

   inst_fetch #(
      .ADDR_W  (ADDR_W),
      .INST_W  (INST_W),
      .RESET_PC(32'h0),
      .DEPTH   (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .imem       (imem_if),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .if_valid   (if_valid),
      .if_pc      (if_pc),
      .if_inst    (if_inst)
   );

   int                       n_tests = 0;
   int                       n_fail  = 0;
   int                       grant   = 0;
   int                       fire_cnt = 0;
   logic                     ready_en = 1'b0;
   logic                     hold     = 1'b0;
   logic [ADDR_W-1:0]        pend_q[$];
   logic [ADDR_W-1:0]        req_exp_q[$];
   logic [ADDR_W+INST_W-1:0] out_exp_q[$];

   // clock / reset
   initial forever #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, limit 200000ns");
      $fatal(1);
   end

   function automatic logic [INST_W-1:0] inst_of(input logic [ADDR_W-1:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_req(input logic [ADDR_W-1:0] a, input int n);
      for (int i = 0; i < n; i++) req_exp_q.push_back(a + ADDR_W'(4 * i));
      grant += n;
   endtask

   task automatic expect_out(input logic [ADDR_W-1:0] a, input int n);
      logic [ADDR_W-1:0] p;
      for (int i = 0; i < n; i++) begin
         p = a + ADDR_W'(4 * i);
         out_exp_q.push_back({p, inst_of(p)});
      end
   endtask

   task automatic expect_fetch(input logic [ADDR_W-1:0] a, input int n);
      expect_req(a, n);
      expect_out(a, n);
   endtask

   task automatic wait_fires(input string name, input int target);
      int k;
      k = 0;
      while (fire_cnt < target && k < 30) begin
         tick();
         k++;
      end
      check(name, 32'(fire_cnt), 32'(target));
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while ((out_exp_q.size() != 0 || req_exp_q.size() != 0) && k < 60) begin
         tick();
         k++;
      end
      check(name, 32'(out_exp_q.size() + req_exp_q.size()), 32'd0);
      out_exp_q.delete();
      req_exp_q.delete();
   endtask

   // memory model: responds one cycle after a fire unless held
   initial begin
      logic              nxt_v;
      logic [INST_W-1:0] nxt_d;
      logic [ADDR_W-1:0] a;
      nxt_v = 1'b0;
      nxt_d = '0;
      imem_if.imem_req_ready  = 1'b0;
      imem_if.imem_resp_valid = 1'b0;
      imem_if.imem_resp_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend_q.delete();
            nxt_v = 1'b0;
         end else begin
            if (imem_if.imem_req_valid && imem_if.imem_req_ready) begin
               pend_q.push_back(imem_if.imem_req_addr);
               fire_cnt++;
            end
            nxt_v = !hold && (pend_q.size() > 0);
            if (nxt_v) begin
               a     = pend_q.pop_front();
               nxt_d = inst_of(a);
            end
         end
         @(posedge clk);
         #2;
         imem_if.imem_resp_valid = nxt_v;
         imem_if.imem_resp_data  = nxt_v ? nxt_d : '0;
         imem_if.imem_req_ready  = ready_en && (fire_cnt < grant);
      end
   end

   // scoreboard: request side
   initial forever begin
      @(negedge clk);
      if (!rst && imem_if.imem_req_valid && imem_if.imem_req_ready) begin
         if (req_exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_unexpected: addr 0x%0h issued, none expected", imem_if.imem_req_addr);
         end else begin
            check("req_addr", imem_if.imem_req_addr, req_exp_q.pop_front());
         end
      end
   end

   // scoreboard: IF output side
   initial forever begin
      logic [ADDR_W+INST_W-1:0] e;
      @(negedge clk);
      if (!rst) begin
         if (if_valid && !stall && !redirect) begin
            if (out_exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL out_unexpected: pc 0x%0h inst 0x%0h, none expected", if_pc, if_inst);
            end else begin
               e = out_exp_q.pop_front();
               check("if_pc", if_pc, e[ADDR_W+INST_W-1:INST_W]);
               check("if_inst", if_inst, e[INST_W-1:0]);
            end
         end else if (!if_valid) begin
            check("idle_pc", if_pc, 32'd0);
            check("idle_inst", if_inst, 32'd0);
         end
      end
   end

   // directed stimulus
   initial begin
      rst         = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;

      tick();
      @(negedge clk);
      check("rst_req_valid", 32'(imem_if.imem_req_valid), 32'd0);
      check("rst_req_addr", imem_if.imem_req_addr, 32'h0);
      check("rst_if_valid", 32'(if_valid), 32'd0);
      check("rst_if_pc", if_pc, 32'd0);
      check("rst_if_inst", if_inst, 32'd0);

      // sequential fetch, latency 1
      tick();
      rst      = 1'b0;
      ready_en = 1'b1;
      expect_fetch(32'h0, 4);
      @(negedge clk);
      check("t1_valid_c0", 32'(if_valid), 32'd0);
      @(negedge clk);
      check("t1_valid_c1", 32'(if_valid), 32'd0);
      @(negedge clk);
      check("t1_valid_c2", 32'(if_valid), 32'd1);
      check("t1_pc_c2", if_pc, 32'h0);
      @(negedge clk);
      check("t1_pc_c3", if_pc, 32'h4);
      wait_drain("t1_drain");

      // memory not ready: address held
      tick();
      ready_en = 1'b0;
      expect_fetch(32'h10, 2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t2_req_valid_held", 32'(imem_if.imem_req_valid), 32'd1);
         check("t2_req_addr_held", imem_if.imem_req_addr, 32'h10);
      end
      tick();
      ready_en = 1'b1;
      wait_drain("t2_drain");

      // stall with credits exhausted
      begin
         int base;
         tick();
         stall = 1'b1;
         base  = fire_cnt;
         expect_fetch(32'h18, 4);
         repeat (4) @(negedge clk);
         check("t3_req_valid_no_credit", 32'(imem_if.imem_req_valid), 32'd0);
         check("t3_if_valid_held", 32'(if_valid), 32'd1);
         check("t3_if_pc_held", if_pc, 32'h18);
         check("t3_fires_in_stall", 32'(fire_cnt - base), 32'd2);
         tick();
         stall = 1'b0;
         wait_drain("t3_drain");
      end

      // redirect with two requests in flight
      begin
         int base;
         tick();
         hold = 1'b1;
         base = fire_cnt;
         expect_req(32'h28, 2);
         wait_fires("t4_fires", base + 2);
         redirect    = 1'b1;
         redirect_pc = 32'h100;
         @(negedge clk);
         check("t4_req_in_redirect", 32'(imem_if.imem_req_valid), 32'd0);
         tick();
         redirect = 1'b0;
         hold     = 1'b0;
         expect_fetch(32'h100, 2);
         wait_drain("t4_drain");
      end

      // redirect coinciding with a response
      begin
         int base;
         tick();
         hold = 1'b1;
         base = fire_cnt;
         expect_req(32'h108, 2);
         wait_fires("t5_fires", base + 2);
         hold = 1'b0;
         tick();
         redirect    = 1'b1;
         redirect_pc = 32'h200;
         @(negedge clk);
         check("t5_req_in_redirect", 32'(imem_if.imem_req_valid), 32'd0);
         tick();
         redirect = 1'b0;
         expect_fetch(32'h200, 2);
         wait_drain("t5_drain");
      end

      // reset with a full buffer
      begin
         int base;
         tick();
         stall = 1'b1;
         base  = fire_cnt;
         expect_req(32'h208, 2);
         wait_fires("t6_fires", base + 2);
         tick();
         @(negedge clk);
         check("t6_full_valid", 32'(if_valid), 32'd1);
         check("t6_full_pc", if_pc, 32'h208);
         check("t6_full_no_req", 32'(imem_if.imem_req_valid), 32'd0);
         tick();
         rst = 1'b1;
         @(negedge clk);
         check("t6_rst_req_valid", 32'(imem_if.imem_req_valid), 32'd0);
         check("t6_rst_if_valid", 32'(if_valid), 32'd0);
         check("t6_rst_if_inst", if_inst, 32'd0);
         tick();
         rst   = 1'b0;
         stall = 1'b0;
         @(negedge clk);
         check("t6_post_rst_valid", 32'(if_valid), 32'd0);
         check("t6_post_rst_addr", imem_if.imem_req_addr, 32'h0);
         tick();
         expect_fetch(32'h0, 2);
         wait_drain("t6_drain");
      end

      repeat (5) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
